comp_operand_sequencer: RTL

COMP_OPERAND_SEQUENCER -- requirements
Module: comp_operand_sequencer

---
 rtl/comp_operand_sequencer.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/comp_operand_sequencer.sv
// Operand sequencer: holds two 3x3 operand matrices and streams them to the
// serial MAC, the 3x3 systolic array or the 2x2 systolic array.
module comp_operand_sequencer #(
  parameter int unsigned DRAIN3 = 4,
  parameter int unsigned DRAIN2 = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic       ld_en,
  input  logic       ld_b,
  input  logic [3:0] ld_addr,
  input  logic [7:0] ld_data,
  output logic [7:0] a_1,
  output logic [7:0] a_2,
  output logic [7:0] a_3,
  output logic [7:0] b_1,
  output logic [7:0] b_2,
  output logic [7:0] b_3,
  output logic [1:0] sel_m,
  output logic       mux_reset,
  output logic       P1_en,
  output logic [1:0] P2_en,
  output logic [2:0] c_sel,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned DW     = 8;
  localparam int unsigned N_ELEM = 9;

  localparam logic [1:0] M_NONE = 2'b00;
  localparam logic [1:0] M_SER  = 2'b01;
  localparam logic [1:0] M_S3   = 2'b10;
  localparam logic [1:0] M_S2   = 2'b11;

  localparam logic [CNT_W-1:0] SER_LAST  = CNT_W'(26);
  localparam logic [CNT_W-1:0] S3_LAST   = CNT_W'(4);
  localparam logic [CNT_W-1:0] S2_LAST   = CNT_W'(2);
  localparam logic [CNT_W-1:0] READ_LAST = CNT_W'(3);
  localparam logic [CNT_W-1:0] D3_LAST   = CNT_W'(DRAIN3 - 1);
  localparam logic [CNT_W-1:0] D2_LAST   = CNT_W'(DRAIN2 - 1);
  localparam logic             HAS_D3    = (DRAIN3 != 0);
  localparam logic             HAS_D2    = (DRAIN2 != 0);

  typedef enum logic [2:0] {S_IDLE, S_FEED, S_DRAIN, S_READ, S_DONE} state_t;

  state_t               state_q;
  logic [1:0]           mode_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [1:0]           i_q, j_q, k_q;
  logic [DW-1:0]        mat_a_q [N_ELEM];
  logic [DW-1:0]        mat_b_q [N_ELEM];

  logic [2:0][DW-1:0]   a_q, a_d, b_q, b_d;
  logic [1:0]           sel_m_q;
  logic                 mux_q, mux_d;
  logic                 p1_q, p1_d;
  logic [1:0]           p2_q, p2_d;
  logic [2:0]           csel_q, csel_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [CNT_W-1:0]     lane_lim;
  int                   lane_cnt;

  assign a_1       = a_q[0];
  assign a_2       = a_q[1];
  assign a_3       = a_q[2];
  assign b_1       = b_q[0];
  assign b_2       = b_q[1];
  assign b_3       = b_q[2];
  assign sel_m     = sel_m_q;
  assign mux_reset = mux_q;
  assign P1_en     = p1_q;
  assign P2_en     = p2_q;
  assign c_sel     = csel_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // Output values for the current state/cycle; registered on the next edge.
  always_comb begin
    a_d      = '0;
    b_d      = '0;
    mux_d    = 1'b0;
    p1_d     = 1'b0;
    p2_d     = 2'b00;
    csel_d   = 3'd0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    lane_lim = '0;
    lane_cnt = 0;
    if (mode_q == M_S3) begin
      lane_lim = CNT_W'(2);
      lane_cnt = 3;
    end else if (mode_q == M_S2) begin
      lane_lim = CNT_W'(1);
      lane_cnt = 2;
    end
    case (state_q)
      S_FEED: begin
        busy_d = 1'b1;
        if (mode_q == M_SER) begin
          a_d[0] = mat_a_q[4'(i_q) * 4'd3 + 4'(k_q)];
          b_d[0] = mat_b_q[4'(k_q) * 4'd3 + 4'(j_q)];
          mux_d  = (k_q == 2'd0);
        end else begin
          p1_d = (mode_q == M_S3);
          p2_d = (mode_q == M_S2) ? 2'b01 : 2'b00;
          // Lane l is skewed by l cycles: row l of A, column l of B.
          for (int l = 0; l < 3; l++) begin
            if (l < lane_cnt && cnt_q >= CNT_W'(l) &&
                (cnt_q - CNT_W'(l)) <= lane_lim) begin
              a_d[l] = mat_a_q[4'(3 * l) + 4'(cnt_q - CNT_W'(l))];
              b_d[l] = mat_b_q[4'(cnt_q - CNT_W'(l)) * 4'd3 + 4'(l)];
            end
          end
        end
      end
      S_DRAIN: begin
        busy_d = 1'b1;
        p1_d   = (mode_q == M_S3);
        p2_d   = (mode_q == M_S2) ? 2'b01 : 2'b00;
      end
      S_READ: begin
        busy_d = 1'b1;
        p2_d   = 2'b10;
        csel_d = 3'(cnt_q);
      end
      S_DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  // State machine, matrix store and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      mode_q  <= M_NONE;
      cnt_q   <= '0;
      i_q     <= 2'd0;
      j_q     <= 2'd0;
      k_q     <= 2'd0;
      for (int unsigned e = 0; e < N_ELEM; e++) begin
        mat_a_q[e] <= '0;
        mat_b_q[e] <= '0;
      end
      a_q     <= '0;
      b_q     <= '0;
      sel_m_q <= 2'b00;
      mux_q   <= 1'b0;
      p1_q    <= 1'b0;
      p2_q    <= 2'b00;
      csel_q  <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sel_m_q <= mode_q;
      mux_q   <= mux_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      csel_q  <= csel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;

      if (ld_en && !busy_q && ld_addr <= 4'd8) begin
        if (ld_b) mat_b_q[ld_addr] <= ld_data;
        else      mat_a_q[ld_addr] <= ld_data;
      end

      case (state_q)
        S_IDLE: begin
          if (start && mode != M_NONE) begin
            state_q <= S_FEED;
            mode_q  <= mode;
            cnt_q   <= '0;
            i_q     <= 2'd0;
            j_q     <= 2'd0;
            k_q     <= 2'd0;
          end
        end
        S_FEED: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (mode_q == M_SER) begin
            k_q <= k_q + 2'd1;
            if (k_q == 2'd2) begin
              k_q <= 2'd0;
              j_q <= j_q + 2'd1;
              if (j_q == 2'd2) begin
                j_q <= 2'd0;
                i_q <= i_q + 2'd1;
              end
            end
            if (cnt_q == SER_LAST) state_q <= S_DONE;
          end else if (mode_q == M_S3) begin
            if (cnt_q == S3_LAST) begin
              cnt_q   <= '0;
              state_q <= HAS_D3 ? S_DRAIN : S_DONE;
            end
          end else if (cnt_q == S2_LAST) begin
            cnt_q   <= '0;
            state_q <= HAS_D2 ? S_DRAIN : S_READ;
          end
        end
        S_DRAIN: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (mode_q == M_S3 && cnt_q == D3_LAST) begin
            cnt_q   <= '0;
            state_q <= S_DONE;
          end else if (mode_q == M_S2 && cnt_q == D2_LAST) begin
            cnt_q   <= '0;
            state_q <= S_READ;
          end
        end
        S_READ: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == READ_LAST) begin
            cnt_q   <= '0;
            state_q <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
